mitm_mode_controller: RTL and testbench

//  Sequences MITM mode changes for the UART MITM logic. Debounces and validates the raw one-hot

---
 rtl/mitm_mode_controller.sv | 141 ++++++++++++++
 tb/tb_mitm_mode_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mitm_mode_controller.sv
// rtl/mitm_mode_controller.sv - debounced, bus-idle-gated MITM mode switch sequencer
module mitm_mode_controller #(
    parameter int                        NUM_MITM_MODES  = 4,
    parameter int                        DEBOUNCE_CYCLES = 16,
    parameter int                        QUIET_CYCLES    = 32,
    parameter logic [NUM_MITM_MODES-1:0] DEFAULT_MODE    = NUM_MITM_MODES'(1)
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic [NUM_MITM_MODES-1:0] mode_request,
    input  logic                      if0_recv_new_data,
    input  logic                      if1_recv_new_data,
    input  logic                      fake_if0_busy,
    input  logic                      fake_if1_busy,
    output logic [NUM_MITM_MODES-1:0] mode,
    output logic                      fake_if0_select,
    output logic                      fake_if1_select,
    output logic                      mode_switching,
    output logic                      mode_error
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > QUIET_CYCLES) ? DEBOUNCE_CYCLES : QUIET_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_DRAIN,
        S_QUIET,
        S_COMMIT
    } state_t;

    state_t                      state, state_n;
    logic [CW-1:0]               counter, counter_n;
    logic [NUM_MITM_MODES-1:0]   candidate, candidate_n;
    logic [NUM_MITM_MODES-1:0]   mode_n;
    logic                        sel0_n, sel1_n, switching_n, error_n;
    logic                        req_valid;
    logic                        abort;
    logic                        any_busy;
    logic                        any_recv;

    // One-hot test: nonzero and clearing the lowest set bit leaves nothing.
    assign req_valid = (mode_request != '0) &&
                       ((mode_request & (mode_request - NUM_MITM_MODES'(1))) == '0);
    assign abort     = (mode_request != candidate);
    assign any_busy  = fake_if0_busy | fake_if1_busy;
    assign any_recv  = if0_recv_new_data | if1_recv_new_data;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state           <= S_IDLE;
            counter         <= '0;
            candidate       <= DEFAULT_MODE;
            mode            <= DEFAULT_MODE;
            fake_if0_select <= ~DEFAULT_MODE[0];
            fake_if1_select <= ~DEFAULT_MODE[0];
            mode_switching  <= 1'b0;
            mode_error      <= 1'b0;
        end else begin
            state           <= state_n;
            counter         <= counter_n;
            candidate       <= candidate_n;
            mode            <= mode_n;
            fake_if0_select <= sel0_n;
            fake_if1_select <= sel1_n;
            mode_switching  <= switching_n;
            mode_error      <= error_n;
        end
    end

    always_comb begin
        state_n     = state;
        counter_n   = counter;
        candidate_n = candidate;
        mode_n      = mode;
        sel0_n      = fake_if0_select;
        sel1_n      = fake_if1_select;
        switching_n = mode_switching;
        error_n     = !req_valid;

        case (state)
            S_IDLE: begin
                if (req_valid && (mode_request != mode)) begin
                    candidate_n = mode_request;
                    counter_n   = '0;
                    state_n     = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    counter_n = counter + 1'b1;
                    if (counter == DEB_LAST) begin
                        state_n     = S_DRAIN;
                        switching_n = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_n     = S_IDLE;
                    switching_n = 1'b0;
                end else if (!any_busy) begin
                    state_n   = S_QUIET;
                    counter_n = '0;
                end
            end
            S_QUIET: begin
                // Priority: abort, then busy, then receive activity restarting the quiet window.
                if (abort) begin
                    state_n     = S_IDLE;
                    switching_n = 1'b0;
                end else if (any_busy) begin
                    state_n = S_DRAIN;
                end else if (any_recv) begin
                    counter_n = '0;
                end else begin
                    counter_n = counter + 1'b1;
                    if (counter == QUIET_LAST) begin
                        state_n = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                mode_n      = candidate;
                sel0_n      = ~candidate[0];
                sel1_n      = ~candidate[0];
                switching_n = 1'b0;
                state_n     = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mitm_mode_controller.sv
// tb/tb_mitm_mode_controller.sv - directed checks of mitm_mode_controller (D=4, Q=8)
module tb_mitm_mode_controller;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mode_request = 4'b0001;
    logic       if0_recv_new_data = 1'b0;
    logic       if1_recv_new_data = 1'b0;
    logic       fake_if0_busy = 1'b0;
    logic       fake_if1_busy = 1'b0;
    logic [3:0] mode;
    logic       fake_if0_select;
    logic       fake_if1_select;
    logic       mode_switching;
    logic       mode_error;

    int checks = 0;
    int errors = 0;

    mitm_mode_controller #(
        .NUM_MITM_MODES (4),
        .DEBOUNCE_CYCLES(4),
        .QUIET_CYCLES   (8),
        .DEFAULT_MODE   (4'b0001)
    ) dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .mode_request     (mode_request),
        .if0_recv_new_data(if0_recv_new_data),
        .if1_recv_new_data(if1_recv_new_data),
        .fake_if0_busy    (fake_if0_busy),
        .fake_if1_busy    (fake_if1_busy),
        .mode             (mode),
        .fake_if0_select  (fake_if0_select),
        .fake_if1_select  (fake_if1_select),
        .mode_switching   (mode_switching),
        .mode_error       (mode_error)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] m, input logic sel,
                                 input logic sw, input logic err);
        check({tag, "_mode"}, 32'(mode), 32'(m));
        check({tag, "_sel0"}, 32'(fake_if0_select), 32'(sel));
        check({tag, "_sel1"}, 32'(fake_if1_select), 32'(sel));
        check({tag, "_switching"}, 32'(mode_switching), 32'(sw));
        check({tag, "_error"}, 32'(mode_error), 32'(err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mode_request = 4'b0001;
        fake_if0_busy = 1'b0;
        fake_if1_busy = 1'b0;
        if0_recv_new_data = 1'b0;
        if1_recv_new_data = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset state
        #1;
        do_reset();
        check_outputs("reset", 4'b0001, 1'b0, 1'b0, 1'b0);

        // 2: clean switch to 0010; switching at edge 5, commit at edge 15
        mode_request = 4'b0010;
        tick(4);
        check_outputs("sw2_e4", 4'b0001, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_outputs("sw2_e5", 4'b0001, 1'b0, 1'b1, 1'b0);
        tick(9);
        check_outputs("sw2_e14", 4'b0001, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_outputs("sw2_e15", 4'b0010, 1'b1, 1'b0, 1'b0);

        // 3: glitch on request shorter than debounce never starts a switch
        do_reset();
        mode_request = 4'b0100;
        tick(2);
        mode_request = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("glitch_switching", 32'(mode_switching), 32'd0);
        end
        check_outputs("glitch_end", 4'b0001, 1'b0, 1'b0, 1'b0);

        // 4: busy holds DRAIN for 20 cycles, recv pulse at QUIET count 5 adds 6 more
        do_reset();
        mode_request = 4'b1000;
        tick(5);
        check_outputs("busy_e5", 4'b0001, 1'b0, 1'b1, 1'b0);
        fake_if1_busy = 1'b1;
        tick(20);
        check_outputs("busy_e25", 4'b0001, 1'b0, 1'b1, 1'b0);
        fake_if1_busy = 1'b0;
        tick(6);
        if0_recv_new_data = 1'b1;
        tick(1);
        if0_recv_new_data = 1'b0;
        tick(3);
        check_outputs("busy_e35", 4'b0001, 1'b0, 1'b1, 1'b0);
        tick(5);
        check_outputs("busy_e40", 4'b0001, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_outputs("busy_e41", 4'b1000, 1'b1, 1'b0, 1'b0);

        // 5: multi-hot request flags an error; a valid request then clears it
        do_reset();
        mode_request = 4'b0011;
        tick(1);
        check_outputs("err_set", 4'b0001, 1'b0, 1'b0, 1'b1);
        tick(3);
        check_outputs("err_hold", 4'b0001, 1'b0, 1'b0, 1'b1);
        mode_request = 4'b1000;
        tick(1);
        check_outputs("err_clr", 4'b0001, 1'b0, 1'b0, 1'b0);
        tick(13);
        check_outputs("err_e14", 4'b0001, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_outputs("err_e15", 4'b1000, 1'b1, 1'b0, 1'b0);

        // 6: reset during QUIET discards the pending switch
        do_reset();
        mode_request = 4'b0100;
        tick(10);
        check_outputs("rstq_e10", 4'b0001, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        mode_request = 4'b0001;
        tick(1);
        check_outputs("rstq_reset", 4'b0001, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(20);
        check_outputs("rstq_after", 4'b0001, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
